// File: rtl/z_alu_pkg.sv
// z_alu_pkg: shared definitions for the Z-series multi-cycle ALU.
//   - opcode encodings OP_ADD..OP_REM and ILLEGAL_MIN (first illegal opcode)
//   - handshake FSM state encoding
//   - is_iter_op(): selects which opcodes run on the iterative mul/div datapath
package z_alu_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_AND = 4'd5;
    localparam logic [3:0] OP_XOR = 4'd6;
    localparam logic [3:0] OP_REM = 4'd7;

    localparam logic [3:0] ILLEGAL_MIN = 4'd8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // MUL only goes iterative when the combinational multiplier is not built.
    function automatic logic is_iter_op(input logic [3:0] op, input logic fast_mul);
        return ((op == OP_MUL) && !fast_mul) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/z_alu_iter_muldiv.sv
// z_alu_iter_muldiv: shared one-bit-per-cycle datapath for shift-add multiply and
// restoring divide.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_start          load operands and begin WIDTH iterations
//   i_div            1: restoring divide, 0: shift-add multiply (sampled on i_start)
//   i_a, i_b         operands (multiplier/multiplicand or dividend/divisor)
//   o_done           high during the cycle whose clock edge performs the last iteration
//   o_lo, o_hi       next-state of shift register / accumulator; on o_done these are
//                    the final {product lo, hi} or {quotient, remainder}
module z_alu_iter_muldiv #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_div,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_done,
    output logic [WIDTH-1:0] o_lo,
    output logic [WIDTH-1:0] o_hi
);

    localparam int unsigned CntW = $clog2(WIDTH);

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             div_q, div_d;

    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] rem_sub;

    always_comb begin
        acc_d   = acc_q;
        sreg_d  = sreg_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        div_d   = div_q;
        o_done  = 1'b0;
        add_sum = {1'b0, acc_q} + {1'b0, b_q};
        rem_sh  = {acc_q, sreg_q[WIDTH-1]};
        // The partial remainder is always below the divisor, so the difference fits WIDTH bits.
        rem_sub = rem_sh[WIDTH-1:0] - b_q;

        if (i_start) begin
            acc_d  = '0;
            sreg_d = i_a;
            b_d    = i_b;
            div_d  = i_div;
            cnt_d  = CntW'(WIDTH - 1);
            busy_d = 1'b1;
        end else if (busy_q) begin
            if (div_q) begin
                // B==0 always "fits": quotient becomes all ones, remainder collects A.
                if (rem_sh >= {1'b0, b_q}) begin
                    acc_d  = rem_sub;
                    sreg_d = {sreg_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d  = rem_sh[WIDTH-1:0];
                    sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
                end
            end else begin
                if (sreg_q[0]) begin
                    {acc_d, sreg_d} = {add_sum, sreg_q[WIDTH-1:1]};
                end else begin
                    {acc_d, sreg_d} = {1'b0, acc_q, sreg_q[WIDTH-1:1]};
                end
            end
            cnt_d = cnt_q - CntW'(1);
            if (cnt_q == '0) begin
                busy_d = 1'b0;
                o_done = 1'b1;
            end
        end

        o_lo = sreg_d;
        o_hi = acc_d;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc_q  <= '0;
            sreg_q <= '0;
            b_q    <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            div_q  <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            sreg_q <= sreg_d;
            b_q    <= b_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            div_q  <= div_d;
        end
    end

endmodule

// File: rtl/z_alu_mc.sv
// z_alu_mc: parametrised multi-cycle unsigned integer ALU with valid/ready handshakes.
// Ports:
//   i_clk, i_rst_n              clock, asynchronous active-low reset
//   i_req_valid / o_req_ready   request handshake; operands and opcode latched at accept
//   i_data_a, i_data_b, i_ctrl  operands and opcode (0 ADD .. 7 REM, 8..15 illegal)
//   o_rsp_valid / i_rsp_ready   response handshake; outputs held while waiting
//   o_data, o_data_hi           result low / high (MUL high product, DIV/REM remainder)
//   o_carry, o_div_zero, o_illegal  status flags for the current response
module z_alu_mc
    import z_alu_pkg::*;
#(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned FAST_MUL = 0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_req_valid,
    output logic             o_req_ready,
    input  logic [WIDTH-1:0] i_data_a,
    input  logic [WIDTH-1:0] i_data_b,
    input  logic [3:0]       i_ctrl,
    output logic             o_rsp_valid,
    input  logic             i_rsp_ready,
    output logic [WIDTH-1:0] o_data,
    output logic [WIDTH-1:0] o_data_hi,
    output logic             o_carry,
    output logic             o_div_zero,
    output logic             o_illegal
);

    state_e state_q, state_d;

    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic             carry_q, carry_d;
    logic             dz_q, dz_d;
    logic             ill_q, ill_d;
    logic [3:0]       op_q, op_d;
    logic             bzero_q, bzero_d;

    logic               accept;
    logic               iter_op;
    logic               md_done;
    logic [WIDTH-1:0]   md_lo;
    logic [WIDTH-1:0]   md_hi;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     sub_dif;
    logic [2*WIDTH-1:0] prod;

    assign accept  = (state_q == S_IDLE) && i_req_valid;
    assign iter_op = is_iter_op(i_ctrl, FAST_MUL != 0);
    assign add_sum = {1'b0, i_data_a} + {1'b0, i_data_b};
    // Top bit of the extended difference is the borrow, i.e. A < B.
    assign sub_dif = {1'b0, i_data_a} - {1'b0, i_data_b};
    assign prod    = {{WIDTH{1'b0}}, i_data_a} * {{WIDTH{1'b0}}, i_data_b};

    z_alu_iter_muldiv #(
        .WIDTH(WIDTH)
    ) u_muldiv (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_start(accept && iter_op),
        .i_div  (i_ctrl != OP_MUL),
        .i_a    (i_data_a),
        .i_b    (i_data_b),
        .o_done (md_done),
        .o_lo   (md_lo),
        .o_hi   (md_hi)
    );

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (i_req_valid) state_d = iter_op ? S_BUSY : S_DONE;
            S_BUSY: if (md_done) state_d = S_DONE;
            S_DONE: if (i_rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake outputs
    always_comb begin
        o_req_ready = (state_q == S_IDLE);
        o_rsp_valid = (state_q == S_DONE);
    end

    // Result and flag registers: cleared at every accept, loaded either at the accept edge
    // (single-cycle ops) or at the final iteration edge.
    always_comb begin
        data_d  = data_q;
        hi_d    = hi_q;
        carry_d = carry_q;
        dz_d    = dz_q;
        ill_d   = ill_q;
        op_d    = op_q;
        bzero_d = bzero_q;

        if (accept) begin
            op_d    = i_ctrl;
            bzero_d = (i_data_b == '0);
            data_d  = '0;
            hi_d    = '0;
            carry_d = 1'b0;
            dz_d    = 1'b0;
            ill_d   = 1'b0;
            if (!iter_op) begin
                case (i_ctrl)
                    OP_ADD: {carry_d, data_d} = add_sum;
                    OP_SUB: begin
                        data_d  = sub_dif[WIDTH-1:0];
                        carry_d = sub_dif[WIDTH];
                    end
                    OP_MUL: {hi_d, data_d} = prod;
                    OP_OR:  data_d = i_data_a | i_data_b;
                    OP_AND: data_d = i_data_a & i_data_b;
                    OP_XOR: data_d = i_data_a ^ i_data_b;
                    default: ill_d = (i_ctrl >= ILLEGAL_MIN);
                endcase
            end
        end else if ((state_q == S_BUSY) && md_done) begin
            dz_d   = bzero_q && (op_q != OP_MUL);
            data_d = (op_q == OP_REM) ? md_hi : md_lo;
            hi_d   = md_hi;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            data_q  <= '0;
            hi_q    <= '0;
            carry_q <= 1'b0;
            dz_q    <= 1'b0;
            ill_q   <= 1'b0;
            op_q    <= OP_ADD;
            bzero_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            hi_q    <= hi_d;
            carry_q <= carry_d;
            dz_q    <= dz_d;
            ill_q   <= ill_d;
            op_q    <= op_d;
            bzero_q <= bzero_d;
        end
    end

    assign o_data     = data_q;
    assign o_data_hi  = hi_q;
    assign o_carry    = carry_q;
    assign o_div_zero = dz_q;
    assign o_illegal  = ill_q;

endmodule

// File: tb/tb_z_alu_mc.sv
`timescale 1ns/1ps
module tb_z_alu_mc;

    typedef struct packed {
        logic [15:0] d;
        logic [15:0] hi;
        logic        c;
        logic        dz;
        logic        ill;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, rsp_valid, rsp_ready;
    logic [15:0] a, b, d, hi;
    logic [3:0]  ctrl;
    logic        carry, dz, ill;

    logic        f_req_valid, f_req_ready, f_rsp_valid, f_rsp_ready;
    logic [15:0] f_a, f_b, f_d, f_hi;
    logic [3:0]  f_ctrl;
    logic        f_carry, f_dz, f_ill;

    int   n_chk  = 0;
    int   n_pass = 0;
    res_t exp_r;
    bit   chk_en = 1'b0;

    always #5 clk = ~clk;

    z_alu_mc #(.WIDTH(16), .FAST_MUL(0)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_data_a(a), .i_data_b(b), .i_ctrl(ctrl),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
        .o_data(d), .o_data_hi(hi),
        .o_carry(carry), .o_div_zero(dz), .o_illegal(ill)
    );

    z_alu_mc #(.WIDTH(16), .FAST_MUL(1)) dut_f (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(f_req_valid), .o_req_ready(f_req_ready),
        .i_data_a(f_a), .i_data_b(f_b), .i_ctrl(f_ctrl),
        .o_rsp_valid(f_rsp_valid), .i_rsp_ready(f_rsp_ready),
        .o_data(f_d), .o_data_hi(f_hi),
        .o_carry(f_carry), .o_div_zero(f_dz), .o_illegal(f_ill)
    );

    // Reference model: plain unsigned arithmetic on the operand values.
    function automatic res_t model(input logic [3:0] op, input logic [15:0] x, input logic [15:0] y);
        res_t        r;
        logic [16:0] s;
        logic [31:0] p;
        r = '0;
        case (op)
            4'd0: begin s = {1'b0, x} + {1'b0, y}; r.d = s[15:0]; r.c = s[16]; end
            4'd1: begin r.d = x - y; r.c = (x < y); end
            4'd2: begin p = {16'd0, x} * {16'd0, y}; r.d = p[15:0]; r.hi = p[31:16]; end
            4'd3: begin
                if (y == 0) begin r.d = 16'hFFFF; r.hi = x; r.dz = 1'b1; end
                else begin r.d = x / y; r.hi = x % y; end
            end
            4'd4: r.d = x | y;
            4'd5: r.d = x & y;
            4'd6: r.d = x ^ y;
            4'd7: begin
                if (y == 0) begin r.d = x; r.hi = x; r.dz = 1'b1; end
                else begin r.d = x % y; r.hi = x % y; end
            end
            default: r.ill = 1'b1;
        endcase
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Every cycle a response is presented, it must match the model of the pending request.
    always @(negedge clk) begin
        if (chk_en && rsp_valid) begin
            check("cmp_data", 32'(d), 32'(exp_r.d));
            check("cmp_hi", 32'(hi), 32'(exp_r.hi));
            check("cmp_carry", 32'(carry), 32'(exp_r.c));
            check("cmp_div_zero", 32'(dz), 32'(exp_r.dz));
            check("cmp_illegal", 32'(ill), 32'(exp_r.ill));
        end
    end

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic run_op(input logic [3:0] op, input logic [15:0] opa, input logic [15:0] opb,
                          input int hold, output res_t got, output int lat);
        exp_r = model(op, opa, opb);
        check("idle_req_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1; ctrl = op; a = opa; b = opb;
        rsp_ready = (hold == 0);
        @(negedge clk);
        // Scramble inputs after accept; they must have no effect.
        req_valid = 1'b0; a = ~opa; b = opa ^ 16'h5A5A; ctrl = 4'hF;
        lat = 1;
        while (!rsp_valid && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        check("latency", 32'(lat), (op == 4'd2 || op == 4'd3 || op == 4'd7) ? 32'd17 : 32'd1);
        got = {d, hi, carry, dz, ill};
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1; ctrl = 4'd0; a = 16'h1111; b = 16'h2222;
            @(negedge clk);
            check("bp_req_ready", 32'(req_ready), 32'd0);
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_stable", {d, hi}, {got.d, got.hi});
        end
        req_valid = 1'b0; rsp_ready = 1'b1;
        @(negedge clk);
        check("post_rsp_ready", 32'(req_ready), 32'd1);
        check("post_rsp_valid", 32'(rsp_valid), 32'd0);
    endtask

    task automatic run_fast(input logic [3:0] op, input logic [15:0] opa, input logic [15:0] opb,
                            output res_t got, output int lat);
        res_t e;
        e = model(op, opa, opb);
        f_req_valid = 1'b1; f_ctrl = op; f_a = opa; f_b = opb;
        @(negedge clk);
        f_req_valid = 1'b0; f_a = 16'hDEAD; f_b = 16'hBEEF;
        lat = 1;
        while (!f_rsp_valid && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        got = {f_d, f_hi, f_carry, f_dz, f_ill};
        check("fast_latency", 32'(lat), (op == 4'd3 || op == 4'd7) ? 32'd17 : 32'd1);
        check("fast_data", 32'(got.d), 32'(e.d));
        check("fast_hi", 32'(got.hi), 32'(e.hi));
        check("fast_flags", {29'd0, got.c, got.dz, got.ill}, {29'd0, e.c, e.dz, e.ill});
        @(negedge clk);
        check("fast_idle", 32'(f_req_ready), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        res_t r;
        int   lat;
        bit   seen;
        rst_n = 1'b0;
        req_valid = 1'b0; rsp_ready = 1'b1; a = '0; b = '0; ctrl = '0;
        f_req_valid = 1'b0; f_rsp_ready = 1'b1; f_a = '0; f_b = '0; f_ctrl = '0;
        repeat (2) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_outputs", {d, hi}, 32'd0);
        check("rst_flags", {29'd0, carry, dz, ill}, 32'd0);
        check("rst_fast_ready", 32'(f_req_ready), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);
        chk_en = 1'b1;

        run_op(4'd0, 16'h0004, 16'h0008, 0, r, lat);
        check("add_lit_data", 32'(r.d), 32'h000C);
        check("add_lit_carry", 32'(r.c), 32'd0);
        check("add_lit_lat", 32'(lat), 32'd1);
        run_op(4'd1, 16'h0004, 16'h0008, 0, r, lat);
        check("sub_lit_data", 32'(r.d), 32'hFFFC);
        check("sub_lit_borrow", 32'(r.c), 32'd1);
        run_op(4'd0, 16'hFFFF, 16'h0001, 0, r, lat);
        check("add_wrap_data", 32'(r.d), 32'h0000);
        check("add_wrap_carry", 32'(r.c), 32'd1);
        run_op(4'hA, 16'h1234, 16'h5678, 0, r, lat);
        check("ill_lit_data", 32'(r.d), 32'd0);
        check("ill_lit_flag", 32'(r.ill), 32'd1);
        run_op(4'd2, 16'h0100, 16'h0100, 0, r, lat);
        check("mul_lit", {r.hi, r.d}, 32'h0001_0000);
        check("mul_lit_lat", 32'(lat), 32'd17);
        run_op(4'd3, 16'd100, 16'd7, 0, r, lat);
        check("div_lit", {r.hi, r.d}, {16'd2, 16'd14});
        run_op(4'd7, 16'd100, 16'd7, 0, r, lat);
        check("rem_lit", 32'(r.d), 32'd2);
        run_op(4'd3, 16'h1234, 16'h0000, 0, r, lat);
        check("div0_lit", {r.hi, r.d}, 32'h1234_FFFF);
        check("div0_flag", 32'(r.dz), 32'd1);
        check("div0_lat", 32'(lat), 32'd17);

        // Backpressure, then immediately another request (accepted the cycle after release).
        run_op(4'd6, 16'hF0F0, 16'h0FF0, 5, r, lat);
        check("xor_lit", 32'(r.d), 32'hFF00);
        run_op(4'd2, 16'hFFFF, 16'hFFFF, 5, r, lat);
        check("mul_max_lit", {r.hi, r.d}, 32'hFFFE_0001);
        run_op(4'd4, 16'hF00F, 16'h0FF0, 0, r, lat);
        run_op(4'd5, 16'hF0F0, 16'hFF00, 0, r, lat);
        run_op(4'd1, 16'h0005, 16'h0005, 0, r, lat);
        run_op(4'd7, 16'h00AB, 16'h0000, 2, r, lat);
        run_op(4'd3, 16'hFFFF, 16'h0001, 0, r, lat);
        run_op(4'd3, 16'h0003, 16'h0009, 0, r, lat);
        run_op(4'hF, 16'hFFFF, 16'hFFFF, 0, r, lat);

        // Reset while a result is held in DONE.
        exp_r = model(4'd0, 16'h1234, 16'h1111);
        req_valid = 1'b1; ctrl = 4'd0; a = 16'h1234; b = 16'h1111; rsp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        check("pre_rst_valid", 32'(rsp_valid), 32'd1);
        check("pre_rst_data", 32'(d), 32'h2345);
        #1 rst_n = 1'b0;
        #1;
        check("rst_done_data", {d, hi}, 32'd0);
        check("rst_done_valid", 32'(rsp_valid), 32'd0);
        check("rst_done_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1; rsp_ready = 1'b1;
        @(negedge clk);

        // Reset in the middle of an iterative divide.
        exp_r = model(4'd3, 16'd100, 16'd7);
        req_valid = 1'b1; ctrl = 4'd3; a = 16'd100; b = 16'd7;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (7) @(negedge clk);
        check("busy_req_ready", 32'(req_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("rst_busy_ready", 32'(req_ready), 32'd1);
        check("rst_busy_valid", 32'(rsp_valid), 32'd0);
        check("rst_busy_data", {d, hi}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        check("no_stale_valid", 32'(seen), 32'd0);
        check("post_rst_ready", 32'(req_ready), 32'd1);
        run_op(4'd3, 16'd1000, 16'd10, 0, r, lat);
        check("div_after_rst", {r.hi, r.d}, {16'd0, 16'd100});

        // FAST_MUL=1 instance.
        run_fast(4'd2, 16'h0100, 16'h0100, r, lat);
        check("fast_mul_lit", {r.hi, r.d}, 32'h0001_0000);
        check("fast_mul_lat", 32'(lat), 32'd1);
        run_fast(4'd2, 16'h1234, 16'h5678, r, lat);
        run_fast(4'd3, 16'd100, 16'd7, r, lat);
        check("fast_div_lit", {r.hi, r.d}, {16'd2, 16'd14});

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
